keypad_key_event_fifo: RTL and testbench

- Downstream consumer of the hex keypad encoder's Code/Valid outputs.
- Qualifies each press: Valid must be high with a steady Code for STABLE_CYCLES clocks.
- Emits exactly one event per physical press, including through release bounce, and buffers events in a small FIFO behind a valid/ready interface.
- The FIFO decouples the scanner from slower consumers such as a display or command decoder.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/key_event_sync_fifo.sv | 64 ++++++
 rtl/keypad_key_event_fifo.sv | 149 ++++++++++++++
 tb/tb_keypad_key_event_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg : shared key-event FSM encoding and key code width
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    KE_IDLE    = 2'd0,
    KE_QUALIFY = 2'd1,
    KE_HELD    = 2'd2,
    KE_RELEASE = 2'd3
  } ke_state_t;

  function automatic logic is_key_held(input ke_state_t s);
    return (s == KE_HELD) || (s == KE_RELEASE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_sync_fifo.sv
// ----------------------------------------------------------------------------
// key_event_sync_fifo : power-of-2 synchronous FIFO with occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module key_event_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);
  assign count = r_count;

  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/keypad_key_event_fifo.sv
// ----------------------------------------------------------------------------
// keypad_key_event_fifo : debounced one-event-per-press qualifier feeding a FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keypad_key_event_fifo
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [KEY_CODE_W-1:0]       code_in,
  input  logic                        valid_in,
  output logic [KEY_CODE_W-1:0]       out_code,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        key_held,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  ke_state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [KEY_CODE_W-1:0] r_code, w_code_nxt;
  logic                  w_match;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  r_key_held;
  logic                  r_overflow;

  assign w_match = valid_in && (code_in == r_code);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= KE_IDLE;
      r_cnt      <= '0;
      r_code     <= '0;
      r_key_held <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_code     <= w_code_nxt;
      r_key_held <= is_key_held(w_state_nxt);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_push      = 1'b0;
    unique case (r_state)
      KE_IDLE: begin
        if (valid_in) begin
          w_code_nxt  = code_in;
          w_cnt_nxt   = c_cnt_one;
          w_state_nxt = KE_QUALIFY;
        end
      end
      KE_QUALIFY: begin
        if (!valid_in) begin
          w_cnt_nxt   = '0;
          w_state_nxt = KE_IDLE;
        end else if (!w_match) begin
          w_code_nxt = code_in;
          w_cnt_nxt  = c_cnt_one;
        end else if (r_cnt == c_cnt_last) begin
          w_push      = 1'b1;
          w_state_nxt = KE_HELD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      KE_HELD: begin
        if (!valid_in) begin
          w_cnt_nxt   = c_cnt_one;
          w_state_nxt = KE_RELEASE;
        end else if (!w_match) begin
          w_code_nxt  = code_in;
          w_cnt_nxt   = c_cnt_one;
          w_state_nxt = KE_QUALIFY;
        end
      end
      KE_RELEASE: begin
        // A return of the same code is release bounce and rejoins HELD silently.
        if (w_match) begin
          w_state_nxt = KE_HELD;
        end else if (valid_in) begin
          w_code_nxt  = code_in;
          w_cnt_nxt   = c_cnt_one;
          w_state_nxt = KE_QUALIFY;
        end else if (r_cnt == c_cnt_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = KE_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = KE_IDLE;
      end
    endcase
  end

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;

  key_event_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clock (clock),
    .rst_n (reset),
    .push  (w_push),
    .din   (r_code),
    .pop   (w_pop),
    .dout  (out_code),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  // Setting has priority so a drop coinciding with a clear is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign key_held = r_key_held;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_keypad_key_event_fifo.sv
// Directed bench for keypad_key_event_fifo: expected key codes are queued when a
// press is driven and compared as the consumer pops them.
`default_nettype none

module tb_keypad_key_event_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] code_in;
  logic       valid_in;
  logic [3:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_count;
  logic       key_held;
  logic       overflow;
  logic       clr_overflow;

  int         total = 0;
  int         bad   = 0;
  int         n_pop = 0;
  logic [3:0] sb[$];

  keypad_key_event_fifo #(
    .STABLE_CYCLES (4),
    .FIFO_DEPTH    (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .code_in      (code_in),
    .valid_in     (valid_in),
    .out_code     (out_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .key_held     (key_held),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check any pop that the coming edge will perform, then advance one clock.
  task automatic cyc();
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 32'(out_valid), 32'd0);
      end else begin
        chk("pop_code", 32'(out_code), 32'(sb.pop_front()));
      end
      n_pop++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic v, input logic [3:0] c, input int n);
    valid_in = v;
    code_in  = c;
    repeat (n) cyc();
  endtask

  initial begin
    reset        = 1'b1;
    valid_in     = 1'b0;
    code_in      = 4'h0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_key_held", 32'(key_held), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;

    // Single press of 7, consumer always ready
    out_ready = 1'b1;
    sb.push_back(4'h7);
    hold(1'b1, 4'h7, 3);
    chk("t1_e3_out_valid", 32'(out_valid), 32'd0);
    chk("t1_e3_key_held", 32'(key_held), 32'd0);
    cyc();
    chk("t1_e4_out_valid", 32'(out_valid), 32'd1);
    chk("t1_e4_out_code", 32'(out_code), 32'h7);
    chk("t1_e4_key_held", 32'(key_held), 32'd1);
    chk("t1_e4_fifo_count", 32'(fifo_count), 32'd1);
    cyc();
    chk("t1_e5_out_valid", 32'(out_valid), 32'd0);
    hold(1'b1, 4'h7, 5);
    hold(1'b0, 4'h7, 3);
    chk("t1_rel3_key_held", 32'(key_held), 32'd1);
    cyc();
    chk("t1_rel4_key_held", 32'(key_held), 32'd0);
    chk("t1_n_pop", 32'(n_pop), 32'd1);

    // Too-short press of A
    hold(1'b1, 4'hA, 3);
    hold(1'b0, 4'hA, 3);
    chk("t2_fifo_count", 32'(fifo_count), 32'd0);
    chk("t2_out_valid", 32'(out_valid), 32'd0);
    chk("t2_key_held", 32'(key_held), 32'd0);

    // Press of 3 with a 2-cycle release glitch
    sb.push_back(4'h3);
    hold(1'b1, 4'h3, 6);
    hold(1'b0, 4'h3, 2);
    chk("t3_glitch_key_held", 32'(key_held), 32'd1);
    hold(1'b1, 4'h3, 5);
    hold(1'b0, 4'h3, 6);
    chk("t3_n_pop", 32'(n_pop), 32'd2);
    chk("t3_fifo_count", 32'(fifo_count), 32'd0);
    chk("t3_key_held", 32'(key_held), 32'd0);

    // Five presses with the consumer stalled: fifth dropped
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) sb.push_back(4'(k));
      hold(1'b1, 4'(k), 5);
      hold(1'b0, 4'(k), 5);
    end
    chk("t4_fifo_count", 32'(fifo_count), 32'd4);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_head_code", 32'(out_code), 32'h1);
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    chk("t4_overflow_clr", 32'(overflow), 32'd0);

    // Full FIFO, qualification edge coincides with a pop
    sb.push_back(4'h6);
    hold(1'b1, 4'h6, 3);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t5_fifo_count", 32'(fifo_count), 32'd4);
    chk("t5_head_code", 32'(out_code), 32'h2);
    chk("t5_overflow", 32'(overflow), 32'd0);
    hold(1'b1, 4'h6, 1);
    hold(1'b0, 4'h6, 5);
    out_ready = 1'b1;
    hold(1'b0, 4'h0, 6);
    chk("t5_drain_count", 32'(fifo_count), 32'd0);
    chk("t5_n_pop", 32'(n_pop), 32'd7);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-HELD with two entries queued
    out_ready = 1'b0;
    sb.push_back(4'h8);
    hold(1'b1, 4'h8, 5);
    hold(1'b0, 4'h8, 5);
    sb.push_back(4'h9);
    hold(1'b1, 4'h9, 6);
    chk("t6_pre_key_held", 32'(key_held), 32'd1);
    chk("t6_pre_fifo_count", 32'(fifo_count), 32'd2);
    reset = 1'b0;
    #2;
    chk("t6_async_out_valid", 32'(out_valid), 32'd0);
    chk("t6_async_out_code", 32'(out_code), 32'd0);
    chk("t6_async_fifo_count", 32'(fifo_count), 32'd0);
    chk("t6_async_key_held", 32'(key_held), 32'd0);
    chk("t6_async_overflow", 32'(overflow), 32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    hold(1'b1, 4'h9, 3);
    chk("t6_no_early_event", 32'(out_valid), 32'd0);
    sb.push_back(4'h9);
    cyc();
    chk("t6_requal_valid", 32'(out_valid), 32'd1);
    chk("t6_requal_code", 32'(out_code), 32'h9);
    chk("t6_requal_count", 32'(fifo_count), 32'd1);

    // Reset mid-QUALIFY after a rollover to C
    hold(1'b1, 4'hC, 2);
    reset = 1'b0;
    #2;
    chk("t6q_async_fifo_count", 32'(fifo_count), 32'd0);
    chk("t6q_async_key_held", 32'(key_held), 32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    hold(1'b0, 4'h0, 2);
    chk("t6q_no_event", 32'(out_valid), 32'd0);
    sb.push_back(4'hC);
    hold(1'b1, 4'hC, 3);
    chk("t6q_e3_out_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("t6q_e4_out_valid", 32'(out_valid), 32'd1);
    chk("t6q_e4_out_code", 32'(out_code), 32'hC);
    out_ready = 1'b1;
    hold(1'b0, 4'h0, 6);
    chk("t6q_final_count", 32'(fifo_count), 32'd0);
    chk("t6q_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
